fft_frame_sink: RTL
===================

Name: fft_frame_sink

Overview:
AXI-Stream slave that consumes complex frames from the FFT core's m_axis_data port, i.e. the output end of the xfft stream. It checks each frame's length against the configured point size and raises tlast protocol events. Completed frames go into a two-bank ping-pong buffer, which a control/readout side drains through a simple addressed read port.

Parameters:
DATA_W, 32, sample width: {im[DATA_W-1:DATA_W/2], re[DATA_W/2-1:0]}, signed halves
LOG2_NMAX, 12, log2 of max frame length; each bank holds 2**LOG2_NMAX words

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
cfg_log2n  in  4  log2 of frame length N; valid range 3..LOG2_NMAX
cfg_valid  in  1  strobe; cfg_log2n is sampled here, takes effect at next frame start
s_axis_data_tdata  in  DATA_W  complex sample
s_axis_data_tvalid  in  1  AXIS valid
s_axis_data_tready  out  1  AXIS ready
s_axis_data_tlast  in  1  last sample of frame
frame_ready  out  1  a completed bank is available for readout
frame_ack  in  1  strobe; releases current read bank
rd_addr  in  LOG2_NMAX  read sample index
rd_data  out  DATA_W  sample at rd_addr, 1-cycle latency
frame_len_log2  out  4  log2n the current read bank was captured with
event_tlast_unexpected  out  1  1-cycle pulse
event_tlast_missing  out  1  1-cycle pulse
frame_count  out  16  completed frames, wraps at 2**16

Behaviour:
- Reset values: tready=0, frame_ready=0, both events=0, frame_count=0, rd_data=0, frame_len_log2=9, active log2n=9, both banks free, write bank=0, read bank=0.
- Reset is asynchronous and takes effect mid-frame. Partial data is discarded and no event pulses.
- Config: cfg_valid loads a pending log2n. The active log2n is updated only in IDLE, before the first sample of the next frame. Out-of-range values are clamped to [3, LOG2_NMAX].
- FSM states are IDLE, CAPTURE, DRAIN and STALL.
- IDLE: tready=1 if the write bank is free, otherwise the FSM goes to STALL with tready=0. The first handshake latches N=2**log2n, writes addr 0 and enters CAPTURE, or jumps directly to the tlast rules below if that beat carries tlast.
- CAPTURE: each handshake writes the sample at index idx, then idx increments.
  - tlast at idx<N-1: pulse event_tlast_unexpected on the following cycle; bank stays free; return to IDLE.
  - tlast at idx==N-1: bank is marked full with its log2n; frame_count increments; write bank toggles; return to IDLE.
  - no tlast at idx==N-1: bank is marked full (frame kept); pulse event_tlast_missing; enter DRAIN.
- DRAIN: tready=1; samples are discarded until a tlast handshake, then return to IDLE.
- STALL: tready=0 until frame_ack frees the bank, then return to IDLE.
- tready is registered. The cycle after the last beat of a frame may show tready=0 while the next bank's state is evaluated; throughput is then at most 1 bubble per frame.
- Read side:
  - frame_ready=1 while the read bank is full.
  - rd_data is registered from read bank[rd_addr], with 1-cycle latency.
  - frame_ack with frame_ready=1 frees the bank and toggles the read bank; the next cycle shows the other bank's status.
  - frame_ack with frame_ready=0 is ignored.
  - rd_addr>=N returns stale RAM content and is not an error.
- Simultaneous events: if frame_ack and a write-bank completion occur in the same cycle, both apply, so that cycle's ack frees a bank and the new frame also completes. A bank completing in the same cycle STALL would exit is handled on the next cycle.

Optional Feature:
FFT_SINK_PWR_EN
- Defined: adds outputs rd_pwr [DATA_W+1 bits] = re*re+im*im (signed products, unsigned sum) and rd_pwr_valid. Both are registered one cycle after rd_data, giving 2-cycle latency from rd_addr. rd_pwr_valid is a delayed rd_addr-sampled strobe, gated by frame_ready. Reset value is 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package fft_sink_pkg: DATA_W, LOG2_NMAX defaults, RE/IM field slice constants, FSM state encoding, default log2n = 9, log2n clamp limits.
- Sub-module sink_bank_ram: simple dual-port RAM (1 write, 1 registered read). It is instantiated once with depth 2*2**LOG2_NMAX, and the bank select is used as the address MSB.

Test Plan:
- Ramp frame: cfg_log2n=9; 512 samples re=idx, im=-idx with tlast on 511 -> frame_ready=1, frame_count=1, rd_addr k returns {-k,k}, no event pulses.
- Short frame: tlast on sample 99 with N=512 -> one event_tlast_unexpected pulse, frame_ready stays 0, the next full 512-frame is captured in bank 0.
- Long frame: 520 samples, tlast only on 519 -> event_tlast_missing pulse after sample 511, samples 512..519 discarded, frame_ready=1 holding the first 512.
- Backpressure: three back-to-back 64-point frames with no ack -> tready=0 after frame 2; frame_ack -> frame 3 resumes; readout order is frame1, frame2, frame3, all data intact.
- Config timing: cfg_valid with log2n=6 mid 512-frame -> the current frame completes at 512 (frame_len_log2=9), the next frame at 64 (frame_len_log2=6).
- Reset mid-capture after 200 samples -> all outputs return to reset values, no events, the next frame captures cleanly; with FFT_SINK_PWR_EN, sample {3,4} gives rd_pwr=25 two cycles after rd_addr.

Source files
------------

// File: rtl/fft_sink_pkg.sv
// fft_sink_pkg: shared constants, types and helpers for the fft_frame_sink block.
//   - default data width and maximum frame size
//   - re/im field positions within a sample word: {im, re}, signed halves
//   - capture FSM state encoding
//   - frame-size clamp helper
package fft_sink_pkg;

   localparam int unsigned DATA_W_DEF    = 32;
   localparam int unsigned LOG2_NMAX_DEF = 12;

   // Field slices for the default width; re in the low half, im in the high half.
   localparam int unsigned RE_LSB_DEF = 0;
   localparam int unsigned RE_MSB_DEF = DATA_W_DEF / 2 - 1;
   localparam int unsigned IM_LSB_DEF = DATA_W_DEF / 2;
   localparam int unsigned IM_MSB_DEF = DATA_W_DEF - 1;

   localparam logic [3:0] LOG2N_DEFAULT = 4'd9;
   localparam logic [3:0] LOG2N_MIN     = 4'd3;

   typedef enum logic [1:0] {
      StIdle,
      StCapture,
      StDrain,
      StStall
   } sink_state_e;

   function automatic logic [3:0] clamp_log2n(input logic [3:0] val, input logic [3:0] vmax);
      logic [3:0] res;
      res = val;
      if (val < LOG2N_MIN) res = LOG2N_MIN;
      else if (val > vmax) res = vmax;
      return res;
   endfunction

endpackage

// File: rtl/sink_bank_ram.sv
// sink_bank_ram: simple dual-port RAM, one write port and one registered read port.
// Ports:
//   aclk, aresetn        clock, async active-low reset (read register only)
//   we, waddr, wdata     write port
//   raddr, rdata         read port, rdata valid one cycle after raddr
module sink_bank_ram #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 13
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [2**ADDR_W];

   always_ff @(posedge aclk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rdata <= '0;
      else          rdata <= mem[raddr];
   end

endmodule

// File: rtl/fft_frame_sink.sv
// fft_frame_sink: AXI-Stream slave capturing fixed-length complex FFT frames into a
// two-bank ping-pong buffer with an addressed readout port.
// Optional feature macro: FFT_SINK_PWR_EN adds rd_pwr / rd_pwr_valid (|x|^2 readout).
// Ports:
//   aclk, aresetn                clock, async active-low reset
//   cfg_log2n, cfg_valid         frame length config, applied at next frame start
//   s_axis_data_*                AXIS slave (tdata, tvalid, tready, tlast)
//   frame_ready, frame_ack       read bank full / release strobe
//   rd_addr, rd_data             sample readout, 1-cycle latency
//   frame_len_log2               log2n of the current read bank
//   event_tlast_unexpected/missing  1-cycle protocol event pulses
//   frame_count                  completed frame counter (wraps)
module fft_frame_sink
   import fft_sink_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned LOG2_NMAX = LOG2_NMAX_DEF
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [3:0]           cfg_log2n,
   input  logic                 cfg_valid,
   input  logic [DATA_W-1:0]    s_axis_data_tdata,
   input  logic                 s_axis_data_tvalid,
   output logic                 s_axis_data_tready,
   input  logic                 s_axis_data_tlast,
   output logic                 frame_ready,
   input  logic                 frame_ack,
   input  logic [LOG2_NMAX-1:0] rd_addr,
   output logic [DATA_W-1:0]    rd_data,
   output logic [3:0]           frame_len_log2,
   output logic                 event_tlast_unexpected,
   output logic                 event_tlast_missing,
   output logic [15:0]          frame_count
`ifdef FFT_SINK_PWR_EN
   ,
   output logic [DATA_W:0]      rd_pwr,
   output logic                 rd_pwr_valid
`endif
);

   localparam logic [LOG2_NMAX:0] ONE = 1;

   sink_state_e            state_q, state_d;
   logic                   tready_q, tready_d;
   logic [LOG2_NMAX-1:0]   idx_q, idx_d;
   logic [3:0]             active_q, active_d;
   logic [3:0]             pend_q, pend_d;
   logic                   pend_v_q, pend_v_d;
   logic [1:0]             full_q, full_d;
   logic [1:0][3:0]        len_q, len_d;
   logic                   wr_bank_q, wr_bank_d;
   logic                   rd_bank_q, rd_bank_d;
   logic [15:0]            cnt_q, cnt_d;
   logic                   unexp_q, unexp_d;
   logic                   miss_q, miss_d;

   logic                   hs;
   logic                   beat;
   logic                   we;
   logic [LOG2_NMAX-1:0]   beat_idx;
   logic [3:0]             frame_log2n;
   logic [LOG2_NMAX:0]     n_full;
   logic [LOG2_NMAX:0]     n_m1;
   logic [LOG2_NMAX-1:0]   n_last;

   assign hs       = tready_q & s_axis_data_tvalid;
   // First beat of a frame is always index 0; the pending config wins if it is waiting.
   assign beat_idx    = (state_q == StIdle) ? '0 : idx_q;
   assign frame_log2n = (state_q == StIdle && pend_v_q) ? pend_q : active_q;
   assign n_full      = ONE << frame_log2n;
   assign n_m1        = n_full - ONE;
   assign n_last      = n_m1[LOG2_NMAX-1:0];

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      active_d  = active_q;
      pend_d    = pend_q;
      pend_v_d  = pend_v_q;
      full_d    = full_q;
      len_d     = len_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      cnt_d     = cnt_q;
      unexp_d   = 1'b0;
      miss_d    = 1'b0;
      beat      = 1'b0;
      tready_d  = 1'b0;

      if (cfg_valid) begin
         pend_d   = clamp_log2n(cfg_log2n, 4'(LOG2_NMAX));
         pend_v_d = 1'b1;
      end

      // Ack is applied first so a same-cycle completion into the other bank also lands.
      if (frame_ack && full_q[rd_bank_q]) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end

      case (state_q)
         StIdle: begin
            if (pend_v_q) begin
               active_d = pend_q;
               pend_v_d = cfg_valid;
            end
            if (full_q[wr_bank_q]) state_d = StStall;
            else if (hs)           beat    = 1'b1;
         end
         StCapture: begin
            if (hs) beat = 1'b1;
         end
         StDrain: begin
            if (hs && s_axis_data_tlast) state_d = StIdle;
         end
         StStall: begin
            if (!full_q[wr_bank_q]) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (beat) begin
         if (s_axis_data_tlast && beat_idx != n_last) begin
            unexp_d = 1'b1;
            idx_d   = '0;
            state_d = StIdle;
         end else if (beat_idx == n_last) begin
            full_d[wr_bank_q] = 1'b1;
            len_d[wr_bank_q]  = frame_log2n;
            cnt_d             = cnt_q + 16'd1;
            wr_bank_d         = ~wr_bank_q;
            idx_d             = '0;
            miss_d            = ~s_axis_data_tlast;
            state_d           = s_axis_data_tlast ? StIdle : StDrain;
         end else begin
            idx_d   = beat_idx + LOG2_NMAX'(1);
            state_d = StCapture;
         end
      end

      // tready is registered, so it is derived from the state we are about to enter.
      case (state_d)
         StIdle:    tready_d = ~full_d[wr_bank_d];
         StCapture: tready_d = 1'b1;
         StDrain:   tready_d = 1'b1;
         default:   tready_d = 1'b0;
      endcase
   end

   assign we = beat;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= StIdle;
         tready_q  <= 1'b0;
         idx_q     <= '0;
         active_q  <= LOG2N_DEFAULT;
         pend_q    <= LOG2N_DEFAULT;
         pend_v_q  <= 1'b0;
         full_q    <= '0;
         len_q     <= {2{LOG2N_DEFAULT}};
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         cnt_q     <= '0;
         unexp_q   <= 1'b0;
         miss_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tready_q  <= tready_d;
         idx_q     <= idx_d;
         active_q  <= active_d;
         pend_q    <= pend_d;
         pend_v_q  <= pend_v_d;
         full_q    <= full_d;
         len_q     <= len_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         cnt_q     <= cnt_d;
         unexp_q   <= unexp_d;
         miss_q    <= miss_d;
      end
   end

   // Bank select is the address MSB.
   sink_bank_ram #(
      .WIDTH  (DATA_W),
      .ADDR_W (LOG2_NMAX + 1)
   ) u_ram (
      .aclk    (aclk),
      .aresetn (aresetn),
      .we      (we),
      .waddr   ({wr_bank_q, beat_idx}),
      .wdata   (s_axis_data_tdata),
      .raddr   ({rd_bank_q, rd_addr}),
      .rdata   (rd_data)
   );

   assign s_axis_data_tready     = tready_q;
   assign frame_ready            = full_q[rd_bank_q];
   assign frame_len_log2         = len_q[rd_bank_q];
   assign event_tlast_unexpected = unexp_q;
   assign event_tlast_missing    = miss_q;
   assign frame_count            = cnt_q;

`ifdef FFT_SINK_PWR_EN
   localparam int unsigned HALF_W = DATA_W / 2;

   logic signed [HALF_W-1:0] pwr_re;
   logic signed [HALF_W-1:0] pwr_im;
   logic signed [DATA_W-1:0] re_sq;
   logic signed [DATA_W-1:0] im_sq;
   logic                     pwr_v1_q;

   assign pwr_re = signed'(rd_data[HALF_W-1:0]);
   assign pwr_im = signed'(rd_data[DATA_W-1:HALF_W]);
   assign re_sq  = pwr_re * pwr_re;
   assign im_sq  = pwr_im * pwr_im;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pwr_v1_q     <= 1'b0;
         rd_pwr_valid <= 1'b0;
         rd_pwr       <= '0;
      end else begin
         pwr_v1_q     <= frame_ready;
         rd_pwr_valid <= pwr_v1_q;
         rd_pwr       <= {1'b0, re_sq} + {1'b0, im_sq};
      end
   end
`endif

endmodule
